// File: rtl/spi_activity_monitor.sv
// Multi-channel SPI clock activity monitor: counts synchronised SCLK rising edges per
// fixed CLK window and reports edge counts, DETECT with miss hysteresis and sticky LOST.
module spi_activity_monitor #(
    parameter int NUM_CH        = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int WINDOW_CYCLES = 64,
    parameter int CNT_W         = 8,
    parameter int MIN_EDGES     = 2,
    parameter int MISS_WINDOWS  = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_CH-1:0]       SCLK,
    input  logic                    CLR,
    output logic [NUM_CH-1:0]       DETECT,
    output logic [NUM_CH-1:0]       LOST,
    output logic [NUM_CH*CNT_W-1:0] EDGE_COUNT,
    output logic                    WINDOW_DONE
);

    localparam int TW = $clog2(WINDOW_CYCLES);
    localparam int MW = $clog2(MISS_WINDOWS + 1);
    localparam logic [TW-1:0]    TC_VAL   = TW'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_E    = CNT_W'(MIN_EDGES);
    localparam logic [MW-1:0]    MISS_MAX = MW'(MISS_WINDOWS);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } det_state_e;

    logic [TW-1:0] timer_q, timer_d;
    logic          tc;
    logic          done_q;

    always_comb begin
        tc      = (timer_q == TC_VAL);
        timer_d = tc ? '0 : timer_q + TW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            timer_q <= '0;
            done_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            done_q  <= tc;
        end
    end

    assign WINDOW_DONE = done_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   edge_det;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic [CNT_W-1:0]       count_q, count_d;
        logic [CNT_W-1:0]       cap;
        logic [MW-1:0]          miss_q, miss_d;
        logic [MW-1:0]          miss_inc;
        det_state_e             state_q, state_d;
        logic                   lost_q, lost_d;
        logic                   active;

        assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

        // cap includes this cycle's edge so a TC-cycle edge closes with its window
        always_comb begin
            cap      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(edge_det);
            cnt_d    = tc ? '0 : cap;
            count_d  = tc ? cap : count_q;
            active   = (cap >= MIN_E);
            miss_inc = miss_q + MW'(1);
            state_d  = state_q;
            miss_d   = miss_q;
            lost_d   = lost_q & ~CLR;
            if (tc) begin
                case (state_q)
                    ST_IDLE: begin
                        if (active) begin
                            state_d = ST_ACTIVE;
                            miss_d  = '0;
                        end
                    end
                    ST_ACTIVE: begin
                        if (active) begin
                            miss_d = '0;
                        end else if (miss_inc == MISS_MAX) begin
                            state_d = ST_IDLE;
                            miss_d  = '0;
                            lost_d  = 1'b1;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        miss_d  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                sync_q  <= '0;
                prev_q  <= 1'b0;
                cnt_q   <= '0;
                count_q <= '0;
                miss_q  <= '0;
                state_q <= ST_IDLE;
                lost_q  <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], SCLK[g]};
                prev_q  <= sync_q[SYNC_STAGES-1];
                cnt_q   <= cnt_d;
                count_q <= count_d;
                miss_q  <= miss_d;
                state_q <= state_d;
                lost_q  <= lost_d;
            end
        end

        assign DETECT[g]                    = (state_q == ST_ACTIVE);
        assign LOST[g]                      = lost_q;
        assign EDGE_COUNT[g*CNT_W +: CNT_W] = count_q;
    end

endmodule

// File: tb/tb_spi_activity_monitor.sv
// Scoreboard bench for spi_activity_monitor: two instances (CNT_W=8 and CNT_W=4)
// driven identically and checked every cycle against a window-level reference model.
module tb_spi_activity_monitor;

    localparam int NCH  = 2;
    localparam int SS   = 2;
    localparam int W    = 64;
    localparam int MINE = 2;
    localparam int MISS = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CLR;
    logic [1:0]  SCLK;

    logic [1:0]  det_a, lost_a;
    logic [15:0] ec_a;
    logic        done_a;
    logic [1:0]  det_b, lost_b;
    logic [7:0]  ec_b;
    logic        done_b;

    spi_activity_monitor #(
        .NUM_CH(NCH), .SYNC_STAGES(SS), .WINDOW_CYCLES(W),
        .CNT_W(8), .MIN_EDGES(MINE), .MISS_WINDOWS(MISS)
    ) dut_a (
        .CLK(CLK), .RST(RST), .SCLK(SCLK), .CLR(CLR),
        .DETECT(det_a), .LOST(lost_a), .EDGE_COUNT(ec_a), .WINDOW_DONE(done_a)
    );

    spi_activity_monitor #(
        .NUM_CH(NCH), .SYNC_STAGES(SS), .WINDOW_CYCLES(W),
        .CNT_W(4), .MIN_EDGES(MINE), .MISS_WINDOWS(MISS)
    ) dut_b (
        .CLK(CLK), .RST(RST), .SCLK(SCLK), .CLR(CLR),
        .DETECT(det_b), .LOST(lost_b), .EDGE_COUNT(ec_b), .WINDOW_DONE(done_b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       done;
        bit [1:0] det;
        bit [1:0] lost;
        int       ec0;
        int       ec1;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    // Reference model state: raw sample history, unbounded window edge totals.
    bit   hist[NCH][$];
    int   wcnt[NCH];
    int   miss[NCH];
    int   pos;
    exp_t cur;

    function automatic void model_step(bit rst, bit [1:0] s, bit clr);
        int n;
        bit a, b;
        if (rst) begin
            pos      = 0;
            cur.done = 0;
            cur.det  = '0;
            cur.lost = '0;
            cur.ec0  = 0;
            cur.ec1  = 0;
            for (int ch = 0; ch < NCH; ch++) begin
                hist[ch].delete();
                wcnt[ch] = 0;
                miss[ch] = 0;
            end
        end else begin
            pos++;
            cur.done = 0;
            for (int ch = 0; ch < NCH; ch++) begin
                hist[ch].push_back(s[ch]);
                if (hist[ch].size() > SS + 2) void'(hist[ch].pop_front());
                n = hist[ch].size();
                a = (n - 1 - SS >= 0) ? hist[ch][n-1-SS] : 1'b0;
                b = (n - 2 - SS >= 0) ? hist[ch][n-2-SS] : 1'b0;
                if (a && !b) wcnt[ch]++;
                if (clr) cur.lost[ch] = 0;
            end
            if (pos % W == 0) begin
                cur.done = 1;
                cur.ec0  = wcnt[0];
                cur.ec1  = wcnt[1];
                for (int ch = 0; ch < NCH; ch++) begin
                    if (wcnt[ch] >= MINE) begin
                        cur.det[ch] = 1;
                        miss[ch]    = 0;
                    end else if (cur.det[ch]) begin
                        miss[ch]++;
                        if (miss[ch] >= MISS) begin
                            cur.det[ch]  = 0;
                            cur.lost[ch] = 1;
                            miss[ch]     = 0;
                        end
                    end
                    wcnt[ch] = 0;
                end
            end
        end
        exp_q.push_back(cur);
    endfunction

    function automatic int clampv(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic bit per(int t, int p);
        return (t % p) < (p / 2);
    endfunction

    function automatic bit gen(int m, int p, int t);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return per(t, p);
            3:       return 1'($urandom_range(0, 1));
            default: return ($urandom_range(0, 19) == 0);
        endcase
    endfunction

    task automatic cyc(input bit rst, input bit [1:0] s, input bit clr);
        RST  = rst;
        SCLK = s;
        CLR  = clr;
        model_step(rst, s, clr);
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [20:0] want_a, want_b;
            e      = exp_q.pop_front();
            want_a = {e.done, e.det, e.lost, 8'(clampv(e.ec1, 255)), 8'(clampv(e.ec0, 255))};
            want_b = {e.done, e.det, e.lost, 4'(clampv(e.ec1, 15)), 4'(clampv(e.ec0, 15)), 8'h0};
            total++;
            if ({done_a, det_a, lost_a, ec_a} === want_a) passed++;
            else $display("FAIL cnt8 t=%0t got done=%b det=%b lost=%b ec=%h expected done=%b det=%b lost=%b ec=%h",
                          $time, done_a, det_a, lost_a, ec_a, want_a[20], want_a[19:18], want_a[17:16], want_a[15:0]);
            total++;
            if ({done_b, det_b, lost_b, ec_b, 8'h0} === want_b) passed++;
            else $display("FAIL cnt4 t=%0t got done=%b det=%b lost=%b ec=%h expected done=%b det=%b lost=%b ec=%h",
                          $time, done_b, det_b, lost_b, ec_b, want_b[20], want_b[19:18], want_b[17:16], want_b[15:8]);
        end
    end

    initial begin
        int o;
        // Reset held with SCLK toggling
        for (int i = 0; i < 5; i++) cyc(1'b1, (i % 2 != 0) ? 2'b11 : 2'b00, 1'b0);
        // Steady 10-cycle SCLK on ch0, ch1 low
        for (int t = 0; t < 3 * W; t++) cyc(1'b0, {1'b0, per(t, 10)}, 1'b0);
        // Stop: hysteresis then LOST[0]
        for (int t = 0; t < 3 * W; t++) cyc(1'b0, 2'b00, 1'b0);
        // ch1 single edge per window, landing on the TC cycle
        for (int t = 0; t < 3 * W; t++) begin
            o = (pos + 1 + SS) % W;
            cyc(1'b0, {(o == 0 || o == 1), 1'b0}, 1'b0);
        end
        // ch1 exactly two edges per window
        for (int t = 0; t < 3 * W; t++) begin
            o = (pos + 1 + SS) % W;
            cyc(1'b0, {(o == 0 || o == 1 || o == 30 || o == 31), 1'b0}, 1'b0);
        end
        // Saturation on the 4-bit instance: period 4 on ch0
        for (int t = 0; t < 2 * W; t++) begin
            o = (pos + 1 + SS) % W;
            cyc(1'b0, {(o == 0 || o == 1 || o == 30 || o == 31), per(t, 4)}, 1'b0);
        end
        // Mid-window CLR clears sticky flags, DETECT untouched
        for (int t = 0; t < 2 * W; t++) cyc(1'b0, {1'b0, per(t, 10)}, (t >= 10 && t < 13));
        // CLR on the set cycle and on the cycle after
        for (int t = 0; t < 3 * W; t++) begin
            o = (pos + 1) % W;
            cyc(1'b0, 2'b00, (o == 0 || o == 1));
        end
        // Randomized windows with occasional reset and CLR
        for (int w = 0; w < 20; w++) begin
            int m0, m1, p0, p1;
            m0 = $urandom_range(0, 4);
            m1 = $urandom_range(0, 4);
            p0 = $urandom_range(2, 14);
            p1 = $urandom_range(2, 14);
            for (int t = 0; t < W; t++) begin
                bit [1:0] s;
                s[0] = gen(m0, p0, t);
                s[1] = gen(m1, p1, t);
                cyc(($urandom_range(0, 299) == 0), s, ($urandom_range(0, 31) == 0));
            end
        end
        cyc(1'b0, 2'b00, 1'b0);
        @(negedge CLK);
        #1;
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
